// File: rtl/key_move_ctrl.sv
// key_move_ctrl
// Turns one-cycle key-press pulses into a smooth, frame-paced player move.
// Each accepted press moves the player STEP pixels per frame_tick for
// MOVE_FRAMES ticks, clamped to the visible area; one further press can be
// queued while a move is in progress.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   frame_tick        one-cycle pulse per frame
//   up/down/left/right_flag   one-cycle key-press pulses
//   pos_x, pos_y      player top-left corner
//   moving            high while a move is in progress
//   dir               current/last direction (0 up, 1 down, 2 left, 3 right)
//   hit_edge          one-cycle pulse when a step was clamped
//
// state | meaning
// IDLE  | no move in progress, waiting for a press
// MOVE  | stepping on each frame_tick, pending slot may hold a queued press
module key_move_ctrl #(
    parameter int H_MAX       = 640,
    parameter int V_MAX       = 480,
    parameter int OBJ_W       = 32,
    parameter int OBJ_H       = 32,
    parameter int STEP        = 4,
    parameter int MOVE_FRAMES = 8,
    parameter int X_INIT      = 304,
    parameter int Y_INIT      = 224
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       up_flag,
    input  logic       down_flag,
    input  logic       left_flag,
    input  logic       right_flag,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       moving,
    output logic [1:0] dir,
    output logic       hit_edge
);

    localparam int CW = $clog2(MOVE_FRAMES + 1);
    localparam logic [10:0]   XMAX     = 11'(H_MAX - OBJ_W);
    localparam logic [10:0]   YMAX     = 11'(V_MAX - OBJ_H);
    localparam logic [10:0]   STEP11   = 11'(STEP);
    localparam logic [CW-1:0] CNT_LAST = CW'(MOVE_FRAMES - 1);

    typedef enum logic {IDLE, MOVE} state_t;

    state_t        state_q, state_d;
    logic [9:0]    pos_x_q, pos_x_d;
    logic [9:0]    pos_y_q, pos_y_d;
    logic [1:0]    dir_q, dir_d;
    logic          hit_edge_q, hit_edge_d;
    logic          pend_vld_q, pend_vld_d;
    logic [1:0]    pend_dir_q, pend_dir_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          any_flag;
    logic [1:0]    flag_dir;
    logic [10:0]   x_ext, y_ext;
    logic [9:0]    x_nxt, y_nxt;
    logic          clamp;

    assign any_flag = up_flag | down_flag | left_flag | right_flag;
    assign flag_dir = up_flag   ? 2'd0 :
                      down_flag ? 2'd1 :
                      left_flag ? 2'd2 : 2'd3;

    // One step in the current direction, widened to 11 bits so the
    // comparisons cannot wrap.
    always_comb begin
        x_ext = {1'b0, pos_x_q};
        y_ext = {1'b0, pos_y_q};
        x_nxt = pos_x_q;
        y_nxt = pos_y_q;
        clamp = 1'b0;
        case (dir_q)
            2'd0: if (y_ext < STEP11) begin
                      y_nxt = '0;
                      clamp = 1'b1;
                  end else begin
                      y_nxt = 10'(y_ext - STEP11);
                  end
            2'd1: if (y_ext + STEP11 > YMAX) begin
                      y_nxt = 10'(YMAX);
                      clamp = 1'b1;
                  end else begin
                      y_nxt = 10'(y_ext + STEP11);
                  end
            2'd2: if (x_ext < STEP11) begin
                      x_nxt = '0;
                      clamp = 1'b1;
                  end else begin
                      x_nxt = 10'(x_ext - STEP11);
                  end
            default: if (x_ext + STEP11 > XMAX) begin
                      x_nxt = 10'(XMAX);
                      clamp = 1'b1;
                  end else begin
                      x_nxt = 10'(x_ext + STEP11);
                  end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        dir_d      = dir_q;
        hit_edge_d = 1'b0;
        pend_vld_d = pend_vld_q;
        pend_dir_d = pend_dir_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                // A frame_tick coinciding with the accepting press is ignored.
                if (any_flag) begin
                    dir_d   = flag_dir;
                    cnt_d   = '0;
                    state_d = MOVE;
                end
            end
            MOVE: begin
                if (any_flag) begin
                    pend_vld_d = 1'b1;
                    pend_dir_d = flag_dir;
                end
                if (frame_tick) begin
                    pos_x_d    = x_nxt;
                    pos_y_d    = y_nxt;
                    hit_edge_d = clamp;
                    cnt_d      = cnt_q + 1'b1;
                    if (clamp || cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        // A press in the ending cycle counts as pending and
                        // wins over an older queued press.
                        if (any_flag || pend_vld_q) begin
                            dir_d      = any_flag ? flag_dir : pend_dir_q;
                            pend_vld_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pos_x_q    <= 10'(X_INIT);
            pos_y_q    <= 10'(Y_INIT);
            dir_q      <= 2'd0;
            hit_edge_q <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_dir_q <= 2'd0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            dir_q      <= dir_d;
            hit_edge_q <= hit_edge_d;
            pend_vld_q <= pend_vld_d;
            pend_dir_q <= pend_dir_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign moving   = (state_q == MOVE);
    assign dir      = dir_q;
    assign hit_edge = hit_edge_q;

endmodule

// File: tb/tb_key_move_ctrl.sv
module tb_key_move_ctrl;

    localparam int H_MAX = 640, V_MAX = 480, OBJ_W = 32, OBJ_H = 32;
    localparam int STEP = 4, MF = 8, X_INIT = 304, Y_INIT = 224;
    localparam int XMAX = H_MAX - OBJ_W, YMAX = V_MAX - OBJ_H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       up_flag = 1'b0, down_flag = 1'b0, left_flag = 1'b0, right_flag = 1'b0;
    logic [9:0] pos_x, pos_y;
    logic       moving;
    logic [1:0] dir;
    logic       hit_edge;

    key_move_ctrl #(
        .H_MAX(H_MAX), .V_MAX(V_MAX), .OBJ_W(OBJ_W), .OBJ_H(OBJ_H),
        .STEP(STEP), .MOVE_FRAMES(MF), .X_INIT(X_INIT), .Y_INIT(Y_INIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .up_flag(up_flag), .down_flag(down_flag),
        .left_flag(left_flag), .right_flag(right_flag),
        .pos_x(pos_x), .pos_y(pos_y), .moving(moving),
        .dir(dir), .hit_edge(hit_edge)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit mv;
        int d;
        bit h;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_hits = 0;

    // Reference model: player position as plain integers, queued press as -1/dir.
    int m_x, m_y, m_d, m_pend, m_frames;
    bit m_mv, m_hit;

    function automatic int clip(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_step(input bit rb, input bit tk, input bit u, input bit dn,
                              input bit l, input bit r);
        int fl, tx, ty, nx, ny;
        exp_t e;
        if (!rb) begin
            m_x = X_INIT; m_y = Y_INIT; m_mv = 0; m_d = 0;
            m_hit = 0; m_pend = -1; m_frames = 0;
        end else begin
            fl = u ? 0 : dn ? 1 : l ? 2 : r ? 3 : -1;
            m_hit = 0;
            if (!m_mv) begin
                if (fl >= 0) begin
                    m_d = fl; m_mv = 1; m_frames = 0;
                end
            end else begin
                if (fl >= 0) m_pend = fl;
                if (tk) begin
                    tx = m_x; ty = m_y;
                    case (m_d)
                        0: ty = ty - STEP;
                        1: ty = ty + STEP;
                        2: tx = tx - STEP;
                        default: tx = tx + STEP;
                    endcase
                    nx = clip(tx, XMAX);
                    ny = clip(ty, YMAX);
                    // Clamped whenever the wanted target lies outside the area.
                    m_hit = (nx != tx) || (ny != ty);
                    m_x = nx; m_y = ny;
                    m_frames++;
                    if (m_hit || m_frames == MF) begin
                        if (m_pend >= 0) begin
                            m_d = m_pend; m_pend = -1; m_frames = 0;
                        end else begin
                            m_mv = 0;
                        end
                    end
                end
            end
        end
        if (m_hit) n_hits++;
        e.x = m_x; e.y = m_y; e.mv = m_mv; e.d = m_d; e.h = m_hit;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs at the falling edge; expectation covers the
    // following rising edge.
    task automatic cyc(input bit tk, input bit u, input bit dn, input bit l,
                       input bit r, input bit rb = 1'b1);
        @(negedge clk);
        rst_n = rb; frame_tick = tk;
        up_flag = u; down_flag = dn; left_flag = l; right_flag = r;
        model_step(rb, tk, u, dn, l, r);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
    endtask

    // Monitor: one expectation per clock, sampled just after the rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (int'(pos_x) == e.x && int'(pos_y) == e.y && moving == e.mv &&
                int'(dir) == e.d && hit_edge == e.h) begin
                n_pass++;
            end else begin
                $display("FAIL outputs @%0t: got x=%0d y=%0d moving=%0b dir=%0d hit=%0b, want x=%0d y=%0d moving=%0b dir=%0d hit=%0b",
                         $time, pos_x, pos_y, moving, dir, hit_edge,
                         e.x, e.y, e.mv, e.d, e.h);
            end
        end
    end

    initial begin
        // Reset, then 20 ticks with no presses.
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        ticks(20);

        // Right move over 8 ticks: 308..336.
        cyc(0, 0, 0, 0, 1);
        ticks(10);

        // Up and right together: up wins.
        cyc(0, 1, 0, 0, 1);
        ticks(10);

        // Press coinciding with a tick in IDLE: that tick is ignored.
        cyc(1, 0, 1, 0, 0);
        ticks(9);

        // Pending overwrite: right, down at tick 2, left at tick 4.
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        ticks(14);

        // Reset mid-move after tick 3 of a right move.
        cyc(0, 0, 0, 0, 1);
        ticks(3);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        ticks(2);

        // Drive into each edge until clamps occur.
        for (int k = 0; k < 12; k++) begin cyc(0, 0, 0, 1, 0); ticks(9); end
        for (int k = 0; k < 9; k++)  begin cyc(0, 1, 0, 0, 0); ticks(9); end
        for (int k = 0; k < 22; k++) begin cyc(0, 0, 0, 0, 1); ticks(9); end
        for (int k = 0; k < 16; k++) begin cyc(0, 0, 1, 0, 0); ticks(9); end

        // Random traffic.
        for (int i = 0; i < 6000; i++) begin
            cyc(($urandom_range(0, 3) == 0),
                ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 999) != 0));
        end

        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, want 0", sb.size());
        n_checks++;
        if (n_hits > 0) n_pass++;
        else $display("FAIL edge_coverage: clamp events seen %0d, want >0", n_hits);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
